// File: rtl/rom_scan_controller.sv
// rom_scan_controller
//
// Scans one image out of a pixel ROM in raster order. Each pixel is streamed
// to a consumer over a valid/ready handshake. A start request latches the
// segment select. The controller then walks xoff/yoff across IMG_W x IMG_H.
// For each address it waits ROM_LAT cycles for the ROM data, registers the
// pixel with its coordinates, and holds it until the consumer accepts it.
// Accepted pixels equal to 1 are counted in a saturating counter.
//
// Ports
//   CLK           in   1   clock, rising edge
//   RST           in   1   asynchronous active-high reset
//   start         in   1   one-cycle scan request (honoured only when idle)
//   sel           in   3   ROM segment, sampled with start
//   abort         in   1   terminate the scan in progress, no done pulse
//   xoff / yoff   out  8   ROM column / row address
//   memorySelect  out  3   ROM segment select
//   pixel         in   1   ROM read data, valid ROM_LAT cycles after address
//   pix_out       out  1   streamed pixel value
//   pix_x / pix_y out  8   coordinates of pix_out
//   pix_valid     out  1   pix_out / pix_x / pix_y valid
//   pix_ready     in   1   consumer accepts the pixel
//   busy          out  1   scan in progress
//   done          out  1   one-cycle pulse after the last pixel is accepted
//   ones_count    out  16  accepted 1-pixels in the current or last scan
//
// Every output is a flop. The next values are decoded from the next state,
// so the outputs need no extra cycle of latency.

module rom_scan_controller #(
    parameter int IMG_W   = 160,
    parameter int IMG_H   = 120,
    parameter int ROM_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [2:0]  sel,
    input  logic        abort,
    output logic [7:0]  xoff,
    output logic [7:0]  yoff,
    output logic [2:0]  memorySelect,
    input  logic        pixel,
    output logic        pix_out,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] ones_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WAIT = 3'd2,
        OUT  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [7:0] X_LAST    = 8'(IMG_W - 1);
    localparam logic [7:0] Y_LAST    = 8'(IMG_H - 1);
    // WAIT is entered only when ROM_LAT >= 1; the counter runs ROM_LAT-1 down to 0.
    localparam logic [1:0] WAIT_INIT = (ROM_LAT > 0) ? 2'(ROM_LAT - 1) : 2'd0;

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  wait_cnt_r;
    logic [1:0]  wait_cnt_s;
    logic [7:0]  xoff_s;
    logic [7:0]  yoff_s;
    logic [2:0]  msel_s;
    logic        pix_out_s;
    logic [7:0]  pix_x_s;
    logic [7:0]  pix_y_s;
    logic        pix_valid_s;
    logic        busy_s;
    logic        done_s;
    logic [15:0] ones_s;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Next-state and next-output decode for the scan FSM.
    always_comb begin
        state_s     = state_r;
        wait_cnt_s  = wait_cnt_r;
        xoff_s      = xoff;
        yoff_s      = yoff;
        msel_s      = memorySelect;
        pix_out_s   = pix_out;
        pix_x_s     = pix_x;
        pix_y_s     = pix_y;
        pix_valid_s = pix_valid;
        ones_s      = ones_count;

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = ADDR;
                    msel_s  = sel;
                    xoff_s  = 8'd0;
                    yoff_s  = 8'd0;
                    ones_s  = 16'd0;
                end else begin
                    state_s = IDLE;
                end
            end

            ADDR: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (ROM_LAT == 0) begin
                    // Combinational ROM: the data is already valid in this cycle.
                    state_s     = OUT;
                    pix_out_s   = pixel;
                    pix_x_s     = xoff;
                    pix_y_s     = yoff;
                    pix_valid_s = 1'b1;
                end else begin
                    state_s    = WAIT;
                    wait_cnt_s = WAIT_INIT;
                end
            end

            WAIT: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (wait_cnt_r == 2'd0) begin
                    state_s     = OUT;
                    pix_out_s   = pixel;
                    pix_x_s     = xoff;
                    pix_y_s     = yoff;
                    pix_valid_s = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r - 2'd1;
                end
            end

            OUT: begin
                // Abort wins over a same-cycle acceptance: that pixel is dropped uncounted.
                if (abort) begin
                    state_s     = IDLE;
                    pix_valid_s = 1'b0;
                end else if (pix_valid && pix_ready) begin
                    pix_valid_s = 1'b0;
                    if (pix_out) begin
                        ones_s = sat_inc16(ones_count);
                    end else begin
                        ones_s = ones_count;
                    end
                    if ((xoff == X_LAST) && (yoff == Y_LAST)) begin
                        state_s = DONE;
                    end else begin
                        state_s = ADDR;
                        if (xoff == X_LAST) begin
                            xoff_s = 8'd0;
                            yoff_s = yoff + 8'd1;
                        end else begin
                            xoff_s = xoff + 8'd1;
                        end
                    end
                end else begin
                    state_s = OUT;
                end
            end

            DONE: begin
                state_s = IDLE;
            end

            default: begin
                state_s     = IDLE;
                pix_valid_s = 1'b0;
            end
        endcase

        busy_s = (state_s == ADDR) || (state_s == WAIT) || (state_s == OUT);
        done_s = (state_s == DONE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r      <= IDLE;
            wait_cnt_r   <= 2'd0;
            xoff         <= 8'd0;
            yoff         <= 8'd0;
            memorySelect <= 3'd0;
            pix_out      <= 1'b0;
            pix_x        <= 8'd0;
            pix_y        <= 8'd0;
            pix_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ones_count   <= 16'd0;
        end else begin
            state_r      <= state_s;
            wait_cnt_r   <= wait_cnt_s;
            xoff         <= xoff_s;
            yoff         <= yoff_s;
            memorySelect <= msel_s;
            pix_out      <= pix_out_s;
            pix_x        <= pix_x_s;
            pix_y        <= pix_y_s;
            pix_valid    <= pix_valid_s;
            busy         <= busy_s;
            done         <= done_s;
            ones_count   <= ones_s;
        end
    end

endmodule

// File: tb/tb_rom_scan_controller.sv
// Testbench for rom_scan_controller.
// dut_a: 4x2 image, ROM_LAT=1 (registered ROM model).
// dut_b: 1x1 image, ROM_LAT=0 (combinational ROM model).

module tb_rom_scan_controller;

    localparam int W = 4;
    localparam int H = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut_a signals
    logic        a_start = 1'b0;
    logic [2:0]  a_sel   = 3'd0;
    logic        a_abort = 1'b0;
    logic        a_ready = 1'b1;
    logic        a_pixel;
    logic [7:0]  a_xoff, a_yoff, a_pix_x, a_pix_y;
    logic [2:0]  a_msel;
    logic        a_pix_out, a_pix_valid, a_busy, a_done;
    logic [15:0] a_ones;

    // dut_b signals
    logic        b_start = 1'b0;
    logic [2:0]  b_sel   = 3'd0;
    logic        b_abort = 1'b0;
    logic        b_ready = 1'b1;
    logic        b_pixel;
    logic [7:0]  b_xoff, b_yoff, b_pix_x, b_pix_y;
    logic [2:0]  b_msel;
    logic        b_pix_out, b_pix_valid, b_busy, b_done;
    logic [15:0] b_ones;

    int n_tests = 0;
    int n_fail  = 0;

    // ROM contents: one 8-bit pattern per segment, bit index = y*4 + x.
    function automatic logic rom_bit(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] seg;
        int idx;
        case (s)
            3'd0:    seg = 8'b0000_0000;
            3'd1:    seg = 8'b1011_0010;
            3'd2:    seg = 8'b1111_1111;
            3'd3:    seg = 8'b0100_0001;
            default: seg = 8'b1010_1010;
        endcase
        idx = (int'(y) * W + int'(x)) % 8;
        return seg[idx];
    endfunction

    always @(posedge clk) a_pixel <= rom_bit(a_msel, a_xoff, a_yoff);
    assign b_pixel = rom_bit(b_msel, b_xoff, b_yoff);

    rom_scan_controller #(.IMG_W(W), .IMG_H(H), .ROM_LAT(1)) dut_a (
        .CLK(clk), .RST(rst), .start(a_start), .sel(a_sel), .abort(a_abort),
        .xoff(a_xoff), .yoff(a_yoff), .memorySelect(a_msel), .pixel(a_pixel),
        .pix_out(a_pix_out), .pix_x(a_pix_x), .pix_y(a_pix_y), .pix_valid(a_pix_valid),
        .pix_ready(a_ready), .busy(a_busy), .done(a_done), .ones_count(a_ones)
    );

    rom_scan_controller #(.IMG_W(1), .IMG_H(1), .ROM_LAT(0)) dut_b (
        .CLK(clk), .RST(rst), .start(b_start), .sel(b_sel), .abort(b_abort),
        .xoff(b_xoff), .yoff(b_yoff), .memorySelect(b_msel), .pixel(b_pixel),
        .pix_out(b_pix_out), .pix_x(b_pix_x), .pix_y(b_pix_y), .pix_valid(b_pix_valid),
        .pix_ready(b_ready), .busy(b_busy), .done(b_done), .ones_count(b_ones)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected pixels, filled when a scan is started.
    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       v;
    } pix_t;
    pix_t sbq[$];
    pix_t mon_p;

    int         cyc         = 0;
    int         a_acc_cnt   = 0;
    int         a_done_cnt  = 0;
    int         last_acc    = -1;
    bit         spacing_chk = 1'b0;
    logic [2:0] exp_sel     = 3'd0;

    // Monitor: pops the scoreboard on every acceptance and checks done behaviour.
    always @(negedge clk) begin
        cyc++;
        if (!rst && a_pix_valid && a_ready && !a_abort) begin
            a_acc_cnt++;
            if (sbq.size() == 0) begin
                check("unexpected_pixel", 32'd1, 32'd0);
            end else begin
                mon_p = sbq.pop_front();
                check("pix_x", 32'(a_pix_x), 32'(mon_p.x));
                check("pix_y", 32'(a_pix_y), 32'(mon_p.y));
                check("pix_out", 32'(a_pix_out), 32'(mon_p.v));
                check("msel_at_accept", 32'(a_msel), 32'(exp_sel));
            end
            if (spacing_chk && last_acc >= 0) begin
                check("pixel_spacing", 32'(cyc - last_acc), 32'd3);
            end
            last_acc = cyc;
        end
        if (a_done) begin
            a_done_cnt++;
            check("busy_in_done", 32'(a_busy), 32'd0);
        end
    end

    task automatic begin_scan(input logic [2:0] sel);
        sbq.delete();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                sbq.push_back('{x: 8'(x), y: 8'(y), v: rom_bit(sel, 8'(x), 8'(y))});
            end
        end
        exp_sel     = sel;
        a_acc_cnt   = 0;
        a_done_cnt  = 0;
        last_acc    = -1;
        spacing_chk = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b1;
        a_sel   = sel;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_sel   = 3'd0;
        check("busy_after_start", 32'(a_busy), 32'd1);
        check("msel_after_start", 32'(a_msel), 32'(sel));
        check("xoff_after_start", 32'(a_xoff), 32'd0);
        check("ones_cleared", 32'(a_ones), 32'd0);
    endtask

    task automatic finish_scan(input logic [2:0] sel, input int exp_ones);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        check("pixel_count", 32'(a_acc_cnt), 32'd8);
        check("done_pulses", 32'(a_done_cnt), 32'd1);
        check("ones_count", 32'(a_ones), 32'(exp_ones));
        check("queue_empty", 32'(sbq.size()), 32'd0);
        check("msel_hold", 32'(a_msel), 32'(sel));
    endtask

    task automatic wait_pix(input logic [7:0] x, input logic [7:0] y);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (a_pix_valid && a_pix_x == x && a_pix_y == y) begin
                seen = 1'b1;
                break;
            end
        end
        check("wait_pix_seen", 32'(seen), 32'd1);
    endtask

    typedef struct {
        logic [2:0] sel;
        int         exp_ones;
    } vec_t;
    vec_t vecs[5];

    logic       snap_out;
    logic [7:0] snap_x, snap_y;

    initial begin
        vecs[0] = '{sel: 3'd1, exp_ones: 4};
        vecs[1] = '{sel: 3'd0, exp_ones: 0};
        vecs[2] = '{sel: 3'd2, exp_ones: 8};
        vecs[3] = '{sel: 3'd3, exp_ones: 2};
        vecs[4] = '{sel: 3'd5, exp_ones: 4};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_valid", 32'(a_pix_valid), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_ones", 32'(a_ones), 32'd0);
        check("rst_xy", 32'({a_xoff, a_yoff, a_pix_x, a_pix_y}), 32'd0);
        rst = 1'b0;

        // Full scans with pix_ready held high
        for (int i = 0; i < 5; i++) begin
            begin_scan(vecs[i].sel);
            finish_scan(vecs[i].sel, vecs[i].exp_ones);
        end

        // Start pulsed mid-scan with a different segment is ignored
        begin_scan(3'd1);
        repeat (7) @(posedge clk);
        #1;
        a_start = 1'b1;
        a_sel   = 3'b010;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_sel   = 3'd0;
        finish_scan(3'd1, 4);

        // Backpressure on pixel (2,0)
        begin_scan(3'd1);
        spacing_chk = 1'b0;
        wait_pix(8'd1, 8'd0);
        @(posedge clk); #1;
        a_ready = 1'b0;
        wait_pix(8'd2, 8'd0);
        snap_out = a_pix_out;
        snap_x   = a_pix_x;
        snap_y   = a_pix_y;
        check("bp_pix_out", 32'(a_pix_out), 32'(rom_bit(3'd1, 8'd2, 8'd0)));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", 32'(a_pix_valid), 32'd1);
            check("bp_hold", 32'({a_pix_out, a_pix_x, a_pix_y}), 32'({snap_out, snap_x, snap_y}));
            check("bp_xoff", 32'(a_xoff), 32'd2);
        end
        @(posedge clk); #1;
        a_ready = 1'b1;
        finish_scan(3'd1, 4);

        // Abort in the acceptance cycle of pixel (1,1)
        begin_scan(3'd1);
        spacing_chk = 1'b0;
        wait_pix(8'd0, 8'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_pix_valid", 32'(a_pix_valid), 32'd1);
        check("abort_pix_xy", 32'({a_pix_x, a_pix_y}), 32'({8'd1, 8'd1}));
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_valid", 32'(a_pix_valid), 32'd0);
        check("abort_ones", 32'(a_ones), 32'd2);
        check("abort_left", 32'(sbq.size()), 32'd3);
        sbq.delete();
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(a_done_cnt), 32'd0);
        // Abort while idle has no effect
        @(posedge clk); #1;
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        check("idle_abort_busy", 32'(a_busy), 32'd0);
        check("idle_abort_ones", 32'(a_ones), 32'd2);
        begin_scan(3'd1);
        finish_scan(3'd1, 4);

        // Asynchronous reset in WAIT of pixel (2,0)
        begin_scan(3'd1);
        spacing_chk = 1'b0;
        wait_pix(8'd1, 8'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_xoff", 32'(a_xoff), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_addr", 32'({a_xoff, a_yoff, 5'd0, a_msel}), 32'd0);
        check("async_rst_pix", 32'({a_pix_x, a_pix_y, a_pix_out, a_pix_valid}), 32'd0);
        check("async_rst_flags", 32'({a_busy, a_done}), 32'd0);
        check("async_rst_ones", 32'(a_ones), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sbq.delete();
        check("rst_no_done", 32'(a_done_cnt), 32'd0);
        begin_scan(3'd1);
        finish_scan(3'd1, 4);

        // ROM_LAT=0, 1x1 image
        @(posedge clk); #1;
        b_start = 1'b1;
        b_sel   = 3'd2;
        @(posedge clk); #1;
        b_start = 1'b0;
        b_sel   = 3'd0;
        check("b_c1_valid", 32'(b_pix_valid), 32'd0);
        check("b_c1_busy", 32'(b_busy), 32'd1);
        @(posedge clk); #1;
        check("b_c2_valid", 32'(b_pix_valid), 32'd1);
        check("b_c2_pix", 32'({b_pix_out, b_pix_x, b_pix_y}), 32'({1'b1, 8'd0, 8'd0}));
        check("b_c2_done", 32'(b_done), 32'd0);
        @(posedge clk); #1;
        check("b_c3_done", 32'(b_done), 32'd1);
        check("b_c3_busy", 32'(b_busy), 32'd0);
        check("b_c3_valid", 32'(b_pix_valid), 32'd0);
        check("b_c3_ones", 32'(b_ones), 32'd1);
        @(posedge clk); #1;
        check("b_c4_done", 32'(b_done), 32'd0);
        check("b_c4_ones", 32'(b_ones), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
